backlight_frame_scheduler: RTL and testbench
============================================

BACKLIGHT_FRAME_SCHEDULER -- requirements
Module: backlight_frame_scheduler

Interface
REQ-001 Parameter ZONES, default 360, number of backlight zones copied per frame.
REQ-002 Parameter MIN_LEVEL, default 8, floor applied to every non-zero scaled zone value.
REQ-003 I_clk  in  1  sole clock (pixel clock domain).
REQ-004 I_rst  in  1  reset, synchronous, active-high.
REQ-005 I_vsync  in  1  frame sync level from the LVDS receiver.
REQ-006 I_calc_done  in  1  one-cycle pulse: zone averaging for the frame is complete.
REQ-007 I_bright  in  8  ambient brightness from the light sensor.
REQ-008 O_rd_en / O_rd_addr  out  1 / 9  read request to the zone-average buffer.
REQ-009 I_rd_data  in  8  zone value, valid exactly one cycle after O_rd_en.
REQ-010 O_wr_en / O_wr_addr / O_wr_data  out  1 / 9 / 8  write port into the driver's ping-pong zone RAM.
REQ-011 O_wr_bank  out  1  bank being written; always the inverse of O_disp_bank.
REQ-012 O_disp_bank  out  1  bank the MiniLED driver scans out.
REQ-013 O_busy  out  1  high in any state other than IDLE.
REQ-014 O_drop_cnt  out  8  saturating count of ignored I_calc_done pulses.

Function
REQ-015 States: IDLE, COPY, DRAIN, PEND.
REQ-016 IDLE -> COPY on I_calc_done; I_bright is latched in that same cycle and held for the whole copy.
REQ-017 COPY: O_rd_en is high for exactly ZONES consecutive cycles, with O_rd_addr running 0..ZONES-1 and incrementing by 1 per cycle.
REQ-018 The final read cycle (addr ZONES-1) moves COPY -> DRAIN.
REQ-019 Write latency: O_wr_en/addr/data are registered and asserted 2 cycles after the matching read; O_wr_addr equals the read address.
REQ-020 DRAIN is held until the write of addr ZONES-1 has issued, then moves to PEND.
REQ-021 PEND -> IDLE on the first I_vsync rising edge detected while in PEND; O_disp_bank toggles on that transition cycle.
REQ-022 A vsync edge occurring during COPY or DRAIN does not swap banks; the swap waits for a vsync edge in PEND (no tearing).
REQ-023 Vsync edge detection: I_vsync is registered once; edge = current high AND previous low.
REQ-024 An I_calc_done pulse outside IDLE is ignored and increments O_drop_cnt, which saturates at 255.
REQ-025 If I_calc_done and the swap occur in the same cycle (PEND to IDLE), the pulse counts as a drop.
REQ-026 The read address never exceeds ZONES-1, and no write is issued outside COPY or DRAIN.

Reset
REQ-027 When I_rst is high at a clock edge: state = IDLE, O_disp_bank = 0, O_wr_bank = 1, all enables/addresses/data = 0, O_drop_cnt = 0, O_busy = 0, vsync history = 0.
REQ-028 Reset asserted mid-COPY aborts immediately: no further reads or writes, and no bank swap occurs.

Configuration
REQ-029 Macro BL_BRIGHT_SCALE_EN defined: O_wr_data = (I_rd_data * (latched_bright + 1)) >> 8.
REQ-030 With BL_BRIGHT_SCALE_EN defined, a non-zero result below MIN_LEVEL is raised to MIN_LEVEL, and a zero result stays 0.
REQ-031 BL_BRIGHT_SCALE_EN undefined: O_wr_data = I_rd_data unchanged, I_bright is ignored, and no multiplier is present.
REQ-032 Write latency is 2 cycles in both configurations.

Structure
REQ-033 The shared package holds the state enum, ZONE_ADDR_W = 9, and defaults for ZONES and MIN_LEVEL.
REQ-034 One sub-module, bl_zone_scale, implements the scale-and-floor as a one-register pipeline stage; it reduces to a register when BL_BRIGHT_SCALE_EN is undefined.

Verification
REQ-035 Scenario: reset, calc_done pulse at cycle 10, rd_data = addr[7:0] -> 360 reads on cycles 11..370, 360 writes on cycles 13..372, O_busy high from cycle 11.
REQ-036 Scenario: BL_BRIGHT_SCALE_EN defined, I_bright = 127, rd_data = 200 -> wr_data = 100; rd_data = 4 -> wr_data = 8 (floor applied); rd_data = 0 -> wr_data = 0.
REQ-037 Scenario: vsync rises mid-COPY, then again 50 cycles after DRAIN ends -> O_disp_bank toggles only on the second edge.
REQ-038 Scenario: three calc_done pulses during COPY -> O_drop_cnt = 3, copy completes unaffected; 300 extra pulses -> O_drop_cnt = 255.
REQ-039 Scenario: I_rst asserted at read address 100 -> the next cycle shows O_rd_en = 0 and O_wr_en = 0, state IDLE, O_disp_bank unchanged at 0.
REQ-040 Scenario: BL_BRIGHT_SCALE_EN undefined, I_bright = 0 -> wr_data equals rd_data for all 360 zones.

Source files
------------

// File: rtl/backlight_frame_scheduler_pkg.sv
// Shared types and constants for the backlight frame scheduler.
// Holds the FSM state enum, zone address width and parameter defaults.
package backlight_frame_scheduler_pkg;

  localparam int ZONE_ADDR_W   = 9;
  localparam int ZONES_DEF     = 360;
  localparam int MIN_LEVEL_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_DRAIN,
    S_PEND
  } bl_state_e;

endpackage

// File: rtl/backlight_frame_scheduler_bl_zone_scale.sv
// bl_zone_scale: one-register scale-and-floor stage for zone values.
// Optional macro: BL_BRIGHT_SCALE_EN (scale by brightness, floor at MIN_LEVEL).
// Ports:
//   I_clk, I_rst        clock, synchronous active-high reset
//   in_vld/addr/data    zone read result (data valid with in_vld)
//   bright              latched ambient brightness
//   out_vld/addr/data   registered write request
module bl_zone_scale
  import backlight_frame_scheduler_pkg::*;
#(
  parameter int MIN_LEVEL = MIN_LEVEL_DEF
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   in_vld,
  input  logic [ZONE_ADDR_W-1:0] in_addr,
  input  logic [7:0]             in_data,
  input  logic [7:0]             bright,
  output logic                   out_vld,
  output logic [ZONE_ADDR_W-1:0] out_addr,
  output logic [7:0]             out_data
);

  logic [7:0] data_d;

`ifdef BL_BRIGHT_SCALE_EN
  // 255 * 256 fits in 16 bits, so the >>8 result never exceeds 8 bits.
  logic [15:0] prod;
  logic [7:0]  scaled;
  logic [7:0]  floor_lvl;

  assign floor_lvl = 8'(MIN_LEVEL);
  assign prod      = 16'(in_data) * (16'(bright) + 16'd1);
  assign scaled    = 8'(prod >> 8);

  // Zero stays dark; any lit zone is kept at least at the floor.
  always_comb begin
    data_d = scaled;
    if (scaled != 8'd0 && scaled < floor_lvl)
      data_d = floor_lvl;
  end
`else
  logic unused_bright;

  assign unused_bright = ^bright;
  assign data_d        = in_data;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_vld  <= in_vld;
      out_addr <= in_vld ? in_addr : '0;
      out_data <= in_vld ? data_d : 8'd0;
    end
  end

endmodule

// File: rtl/backlight_frame_scheduler.sv
// backlight_frame_scheduler: copies zone averages into the ping-pong
// driver RAM and swaps banks on vsync once a full frame is written.
// Optional macro: BL_BRIGHT_SCALE_EN (brightness scaling in bl_zone_scale).
// Ports:
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_vsync               frame sync level
//   I_calc_done           zone averages ready (1-cycle pulse)
//   I_bright              ambient brightness
//   O_rd_en/O_rd_addr     read request to average buffer
//   I_rd_data             read data, one cycle after O_rd_en
//   O_wr_en/addr/data     write into driver zone RAM
//   O_wr_bank/O_disp_bank bank being written / scanned out
//   O_busy                not idle
//   O_drop_cnt            saturating count of ignored I_calc_done
module backlight_frame_scheduler
  import backlight_frame_scheduler_pkg::*;
#(
  parameter int ZONES     = ZONES_DEF,
  parameter int MIN_LEVEL = MIN_LEVEL_DEF
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   I_vsync,
  input  logic                   I_calc_done,
  input  logic [7:0]             I_bright,
  output logic                   O_rd_en,
  output logic [ZONE_ADDR_W-1:0] O_rd_addr,
  input  logic [7:0]             I_rd_data,
  output logic                   O_wr_en,
  output logic [ZONE_ADDR_W-1:0] O_wr_addr,
  output logic [7:0]             O_wr_data,
  output logic                   O_wr_bank,
  output logic                   O_disp_bank,
  output logic                   O_busy,
  output logic [7:0]             O_drop_cnt
);

  localparam logic [ZONE_ADDR_W-1:0] LAST = ZONE_ADDR_W'(ZONES - 1);

  bl_state_e state_q;
  bl_state_e state_d;

  logic [ZONE_ADDR_W-1:0] rd_addr_q;
  logic [ZONE_ADDR_W-1:0] rd_addr_d1;
  logic                   rd_vld_q;
  logic [7:0]             bright_q;
  logic                   vs_q;
  logic                   vs_edge;
  logic                   last_rd;
  logic                   last_wr;
  logic                   swap;
  logic                   disp_q;
  logic [7:0]             drop_q;

  assign vs_edge = I_vsync & ~vs_q;
  assign last_rd = O_rd_en & (rd_addr_q == LAST);
  assign last_wr = O_wr_en & (O_wr_addr == LAST);
  assign swap    = (state_q == S_PEND) & vs_edge;

  // State register
  always_ff @(posedge I_clk) begin
    if (I_rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_calc_done) state_d = S_COPY;
      S_COPY:  if (last_rd)     state_d = S_DRAIN;
      S_DRAIN: if (last_wr)     state_d = S_PEND;
      S_PEND:  if (vs_edge)     state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    O_rd_en = 1'b0;
    O_busy  = 1'b1;
    unique case (1'b1)
      (state_q == S_IDLE): O_busy  = 1'b0;
      (state_q == S_COPY): O_rd_en = 1'b1;
      default:             O_busy  = 1'b1;
    endcase
  end

  // Read address walk and read-issued pipeline stage.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rd_addr_q  <= '0;
      rd_addr_d1 <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      if (O_rd_en && !last_rd)
        rd_addr_q <= rd_addr_q + 1'b1;
      else
        rd_addr_q <= '0;
      rd_vld_q   <= O_rd_en;
      rd_addr_d1 <= O_rd_en ? rd_addr_q : '0;
    end
  end

  // Vsync history, bank swap and drop counter.
  // A pulse landing on the swap cycle is still seen in PEND, so it drops.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      vs_q   <= 1'b0;
      disp_q <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      vs_q <= I_vsync;
      if (swap)
        disp_q <= ~disp_q;
      if (I_calc_done && state_q != S_IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

`ifdef BL_BRIGHT_SCALE_EN
  // Brightness frozen for the whole copy so a frame scales uniformly.
  always_ff @(posedge I_clk) begin
    if (I_rst)
      bright_q <= 8'd0;
    else if (state_q == S_IDLE && I_calc_done)
      bright_q <= I_bright;
  end
`else
  logic unused_bright;

  assign unused_bright = ^I_bright;
  assign bright_q      = 8'd0;
`endif

  bl_zone_scale #(
    .MIN_LEVEL (MIN_LEVEL)
  ) u_scale (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .in_vld   (rd_vld_q),
    .in_addr  (rd_addr_d1),
    .in_data  (I_rd_data),
    .bright   (bright_q),
    .out_vld  (O_wr_en),
    .out_addr (O_wr_addr),
    .out_data (O_wr_data)
  );

  assign O_rd_addr   = rd_addr_q;
  assign O_disp_bank = disp_q;
  assign O_wr_bank   = ~disp_q;
  assign O_drop_cnt  = drop_q;

endmodule

// File: tb/tb_backlight_frame_scheduler.sv
// Testbench for backlight_frame_scheduler.
// Scoreboard of expected zone writes, built from a bench-side zone memory.
module tb_backlight_frame_scheduler;

  localparam int ZONES = 360;
  localparam int MINL  = 8;

  logic       I_clk = 1'b0;
  logic       I_rst = 1'b1;
  logic       I_vsync = 1'b0;
  logic       I_calc_done = 1'b0;
  logic [7:0] I_bright = 8'd0;
  logic       O_rd_en;
  logic [8:0] O_rd_addr;
  logic [7:0] I_rd_data = 8'd0;
  logic       O_wr_en;
  logic [8:0] O_wr_addr;
  logic [7:0] O_wr_data;
  logic       O_wr_bank;
  logic       O_disp_bank;
  logic       O_busy;
  logic [7:0] O_drop_cnt;

  always #5 I_clk = ~I_clk;

  backlight_frame_scheduler dut (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_vsync     (I_vsync),
    .I_calc_done (I_calc_done),
    .I_bright    (I_bright),
    .O_rd_en     (O_rd_en),
    .O_rd_addr   (O_rd_addr),
    .I_rd_data   (I_rd_data),
    .O_wr_en     (O_wr_en),
    .O_wr_addr   (O_wr_addr),
    .O_wr_data   (O_wr_data),
    .O_wr_bank   (O_wr_bank),
    .O_disp_bank (O_disp_bank),
    .O_busy      (O_busy),
    .O_drop_cnt  (O_drop_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] mem [0:ZONES-1];
  int         exp_bright = 0;

  function automatic int model(input logic [7:0] d);
    int s;
`ifdef BL_BRIGHT_SCALE_EN
    s = (int'(d) * (exp_bright + 1)) / 256;
    if (s != 0 && s < MINL)
      s = MINL;
`else
    s = int'(d);
`endif
    return s;
  endfunction

  // Zone-average buffer: data one cycle after the read, noise otherwise.
  always @(posedge I_clk)
    I_rd_data <= O_rd_en ? mem[O_rd_addr] : 8'($urandom);

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   rd_idx = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   first_rd = -1;
  int   last_rd = -1;
  int   first_wr = -1;
  int   last_wr = -1;
  logic rd_prev = 1'b0;

  always @(posedge I_clk) cyc <= cyc + 1;

  always @(negedge I_clk) begin
    exp_t e;
    if (I_rst) begin
      q.delete();
      rd_cnt   = 0;
      wr_cnt   = 0;
      rd_prev  = 1'b0;
      first_rd = -1;
      first_wr = -1;
    end else begin
      if (O_rd_en) begin
        if (!rd_prev) begin
          rd_idx   = 0;
          first_rd = cyc;
        end
        chk("rd_addr", 32'(O_rd_addr), rd_idx);
        if (rd_idx < ZONES)
          q.push_back('{rd_idx, model(mem[rd_idx]), cyc + 2});
        rd_idx++;
        rd_cnt++;
        last_rd = cyc;
      end
      rd_prev = O_rd_en;
      if (O_wr_en) begin
        if (wr_cnt == 0)
          first_wr = cyc;
        wr_cnt++;
        last_wr = cyc;
        chk("wr_busy", 32'(O_busy), 1);
        if (q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(O_wr_addr), e.addr);
          chk("wr_data", 32'(O_wr_data), e.data);
          chk("wr_lat", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge I_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    I_rst       = 1'b1;
    I_calc_done = 1'b0;
    I_vsync     = 1'b0;
    tick(3);
    I_rst = 1'b0;
  endtask

  task automatic start_frame(input int b, output int e_cyc);
    exp_bright  = b;
    I_bright    = 8'(b);
    I_calc_done = 1'b1;
    e_cyc       = cyc + 1;
    tick();
    I_calc_done = 1'b0;
    I_bright    = 8'($urandom);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 2000 && wr_cnt < n; i++)
      tick();
    if (wr_cnt < n)
      chk("timeout_writes", wr_cnt, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e;

    // Reset values
    do_reset();
    chk("rst_busy", 32'(O_busy), 0);
    chk("rst_disp", 32'(O_disp_bank), 0);
    chk("rst_wrbank", 32'(O_wr_bank), 1);
    chk("rst_rd_en", 32'(O_rd_en), 0);
    chk("rst_rd_addr", 32'(O_rd_addr), 0);
    chk("rst_wr_en", 32'(O_wr_en), 0);
    chk("rst_wr_addr", 32'(O_wr_addr), 0);
    chk("rst_wr_data", 32'(O_wr_data), 0);
    chk("rst_drop", 32'(O_drop_cnt), 0);

    // Basic frame: rd_data = addr[7:0], pulse lands on cycle 10
    for (int i = 0; i < ZONES; i++)
      mem[i] = 8'(i);
    while (cyc < 9)
      tick();
    start_frame(0, e);
    chk("busy_copy", 32'(O_busy), 1);
    chk("first_rd", first_rd, e);
    wait_writes(ZONES);
    tick(2);
    chk("rd_cnt", rd_cnt, ZONES);
    chk("wr_cnt", wr_cnt, ZONES);
    chk("last_rd", last_rd, e + ZONES - 1);
    chk("first_wr", first_wr, e + 2);
    chk("last_wr", last_wr, e + ZONES + 1);
    chk("q_empty", q.size(), 0);
    tick(5);
    chk("pend_busy", 32'(O_busy), 1);
    chk("pend_disp", 32'(O_disp_bank), 0);
    chk("pend_wrbank", 32'(O_wr_bank), 1);
    // Swap and calc_done on the same cycle: pulse is dropped
    I_vsync     = 1'b1;
    I_calc_done = 1'b1;
    tick();
    I_calc_done = 1'b0;
    chk("swap_disp", 32'(O_disp_bank), 1);
    chk("swap_wrbank", 32'(O_wr_bank), 0);
    chk("swap_busy", 32'(O_busy), 0);
    chk("swap_drop", 32'(O_drop_cnt), 1);
    tick(3);
    chk("idle_rd_en", 32'(O_rd_en), 0);
    chk("idle_busy", 32'(O_busy), 0);
    I_vsync = 1'b0;

    // Vsync mid-copy must not swap; swap on edge 50 cycles after drain
    do_reset();
    for (int i = 0; i < ZONES; i++)
      mem[i] = 8'($urandom);
    start_frame(int'($urandom_range(0, 255)), e);
    tick(100);
    I_vsync = 1'b1;
    tick(2);
    I_vsync = 1'b0;
    chk("vs_copy_disp", 32'(O_disp_bank), 0);
    wait_writes(ZONES);
    tick(50);
    chk("vs_pend_disp", 32'(O_disp_bank), 0);
    chk("vs_pend_busy", 32'(O_busy), 1);
    I_vsync = 1'b1;
    tick();
    chk("vs_swap_disp", 32'(O_disp_bank), 1);
    chk("vs_swap_busy", 32'(O_busy), 0);
    I_vsync = 1'b0;

    // Scaled data pattern plus drops during copy, then saturation
    do_reset();
    for (int i = 0; i < ZONES; i++)
      mem[i] = 8'($urandom);
    mem[0] = 8'd200;
    mem[1] = 8'd4;
    mem[2] = 8'd0;
    mem[3] = 8'd255;
    mem[4] = 8'd1;
    start_frame(127, e);
    tick(20);
    for (int k = 0; k < 3; k++) begin
      I_calc_done = 1'b1;
      tick();
      I_calc_done = 1'b0;
      tick(10);
    end
    chk("drop3", 32'(O_drop_cnt), 3);
    wait_writes(ZONES);
    tick(2);
    chk("drop_rd_cnt", rd_cnt, ZONES);
    chk("drop_wr_cnt", wr_cnt, ZONES);
    chk("drop_q_empty", q.size(), 0);
    I_calc_done = 1'b1;
    tick(300);
    I_calc_done = 1'b0;
    tick();
    chk("drop_sat", 32'(O_drop_cnt), 255);
    chk("drop_disp", 32'(O_disp_bank), 0);

    // Reset at read address 100 aborts the copy
    do_reset();
    for (int i = 0; i < ZONES; i++)
      mem[i] = 8'($urandom);
    start_frame(50, e);
    for (int i = 0; i < 500 && O_rd_addr != 9'd100; i++)
      tick();
    chk("abort_addr", 32'(O_rd_addr), 100);
    I_rst = 1'b1;
    tick();
    chk("abort_rd_en", 32'(O_rd_en), 0);
    chk("abort_wr_en", 32'(O_wr_en), 0);
    chk("abort_busy", 32'(O_busy), 0);
    chk("abort_disp", 32'(O_disp_bank), 0);
    I_rst = 1'b0;
    tick(10);
    chk("abort_rd_cnt", rd_cnt, 0);
    chk("abort_wr_cnt", wr_cnt, 0);
    chk("abort_busy2", 32'(O_busy), 0);
    chk("abort_disp2", 32'(O_disp_bank), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
